// File: rtl/iram_ctl_if.sv
// ---------------------------------------------------------------------------
// iram_ctl_if
// External microcode-memory handshake between iram_ctl and the top-level
// memory controller.
//   mcr_addr      controller -> memory  latched microcode address
//   mcr_data_out  controller -> memory  latched write data
//   mcr_write     controller -> memory  1 = write, 0 = read
//   mcr_req       controller -> memory  request, held until ack or timeout
//   mcr_ack       memory -> controller  one-cycle completion pulse
//   mcr_data_in   memory -> controller  read data, valid with mcr_ack
// ---------------------------------------------------------------------------
interface iram_ctl_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 49
);
    logic [ADDR_W-1:0] mcr_addr;
    logic [DATA_W-1:0] mcr_data_out;
    logic              mcr_write;
    logic              mcr_req;
    logic              mcr_ack;
    logic [DATA_W-1:0] mcr_data_in;

    modport master (
        output mcr_addr,
        output mcr_data_out,
        output mcr_write,
        output mcr_req,
        input  mcr_ack,
        input  mcr_data_in
    );

    modport slave (
        input  mcr_addr,
        input  mcr_data_out,
        input  mcr_write,
        input  mcr_req,
        output mcr_ack,
        output mcr_data_in
    );
endinterface

// File: rtl/iram_ctl.sv
// ---------------------------------------------------------------------------
// iram_ctl
// Microcode instruction-store front end for the CADR sequencer. Serves
// microinstruction fetches and IWR writes either from an on-chip synchronous
// RAM (EXT_MEM=0) or from the top-level memory controller over the mcr
// handshake (EXT_MEM=1) with a timeout watchdog.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   pc            fetch / write address
//   fetch         fetch request level (held by the sequencer until accepted)
//   iwe, iwr      write request and write data
//   promdisabled  1 = microcode RAM active; 0 = PROM serving, fetches ignored
//   iram          last fetched microinstruction (held between fetches)
//   iram_valid    one-cycle pulse when iram was updated
//   busy          external command in flight; new commands refused
//   err_timeout   sticky external timeout flag, cleared only by reset
//   mcr           external memory handshake (master side)
// ---------------------------------------------------------------------------
module iram_ctl #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 49,
    parameter int EXT_MEM = 0,
    parameter int TMO_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch,
    input  logic              iwe,
    input  logic [DATA_W-1:0] iwr,
    input  logic              promdisabled,
    output logic [DATA_W-1:0] iram,
    output logic              iram_valid,
    output logic              busy,
    output logic              err_timeout,
    iram_ctl_if.master        mcr
);

    logic [DATA_W-1:0] iram_r;
    logic              iram_valid_r;
    logic              busy_r;
    logic              err_timeout_r;
    logic              wr_acc_s;
    logic              rd_acc_s;

    // A write always beats a simultaneous fetch; the sequencer re-presents
    // the fetch on a later cycle.
    assign wr_acc_s = iwe & ~busy_r;
    assign rd_acc_s = fetch & promdisabled & ~busy_r & ~iwe;

    assign iram        = iram_r;
    assign iram_valid  = iram_valid_r;
    assign busy        = busy_r;
    assign err_timeout = err_timeout_r;

    generate
        if (EXT_MEM == 0) begin : g_int
            logic [DATA_W-1:0] mem_r [2**ADDR_W];
            logic              unused_s;

            // The handshake is idle in this configuration.
            assign unused_s         = ^{mcr.mcr_ack, mcr.mcr_data_in};
            assign busy_r           = 1'b0;
            assign err_timeout_r    = 1'b0;
            assign mcr.mcr_addr     = {ADDR_W{1'b0}};
            assign mcr.mcr_data_out = {DATA_W{1'b0}};
            assign mcr.mcr_write    = 1'b0;
            assign mcr.mcr_req      = 1'b0;

            // RAM write port; contents are not cleared by reset.
            always_ff @(posedge clk) begin
                if (!reset && wr_acc_s) begin
                    mem_r[pc] <= iwr;
                end
            end

            // Synchronous read straight into the iram holding register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    iram_r       <= {DATA_W{1'b0}};
                    iram_valid_r <= 1'b0;
                end else begin
                    iram_valid_r <= rd_acc_s;
                    if (rd_acc_s) begin
                        iram_r <= mem_r[pc];
                    end
                end
            end
        end else begin : g_ext
            typedef enum logic [0:0] {
                ST_IDLE = 1'b0,
                ST_REQ  = 1'b1
            } state_t;

            state_t            state_r;
            logic [TMO_W-1:0]  timer_r;
            logic [ADDR_W-1:0] mcr_addr_r;
            logic [DATA_W-1:0] mcr_data_out_r;
            logic              mcr_write_r;
            logic              mcr_req_r;

            assign mcr.mcr_addr     = mcr_addr_r;
            assign mcr.mcr_data_out = mcr_data_out_r;
            assign mcr.mcr_write    = mcr_write_r;
            assign mcr.mcr_req      = mcr_req_r;

            // Request/ack sequencer with watchdog; ack is checked before the
            // timer so an ack on the final allowed cycle still completes.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_r        <= ST_IDLE;
                    timer_r        <= {TMO_W{1'b0}};
                    mcr_addr_r     <= {ADDR_W{1'b0}};
                    mcr_data_out_r <= {DATA_W{1'b0}};
                    mcr_write_r    <= 1'b0;
                    mcr_req_r      <= 1'b0;
                    busy_r         <= 1'b0;
                    err_timeout_r  <= 1'b0;
                    iram_r         <= {DATA_W{1'b0}};
                    iram_valid_r   <= 1'b0;
                end else begin
                    iram_valid_r <= 1'b0;
                    case (state_r)
                        ST_IDLE: begin
                            if (wr_acc_s || rd_acc_s) begin
                                mcr_addr_r     <= pc;
                                mcr_data_out_r <= iwr;
                                mcr_write_r    <= iwe;
                                mcr_req_r      <= 1'b1;
                                busy_r         <= 1'b1;
                                timer_r        <= {TMO_W{1'b0}};
                                state_r        <= ST_REQ;
                            end
                        end
                        ST_REQ: begin
                            if (mcr.mcr_ack) begin
                                mcr_req_r <= 1'b0;
                                busy_r    <= 1'b0;
                                state_r   <= ST_IDLE;
                                if (!mcr_write_r) begin
                                    iram_r       <= mcr.mcr_data_in;
                                    iram_valid_r <= 1'b1;
                                end
                            end else if (timer_r == {TMO_W{1'b1}}) begin
                                mcr_req_r     <= 1'b0;
                                busy_r        <= 1'b0;
                                err_timeout_r <= 1'b1;
                                state_r       <= ST_IDLE;
                            end else begin
                                timer_r <= timer_r + {{(TMO_W-1){1'b0}}, 1'b1};
                            end
                        end
                        default: begin
                            mcr_req_r <= 1'b0;
                            busy_r    <= 1'b0;
                            state_r   <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_iram_ctl.sv
// ---------------------------------------------------------------------------
// tb_iram_ctl
// Drives one internal-RAM instance and one external-handshake instance
// (TMO_W=4). Expected values come from an address->word map for the
// internal store and from per-operation ack-delay arithmetic for the
// external path: an ack d cycles after mcr_req rises (d=0 is the first
// high cycle) completes the op when d <= 15, otherwise the op times out
// after 16 high cycles.
// ---------------------------------------------------------------------------
module tb_iram_ctl;

    localparam int AW   = 14;
    localparam int DW   = 49;
    localparam int TMAX = 15;

    logic          clk;
    int            total = 0;
    int            bad   = 0;

    // internal-RAM instance
    logic          i_reset, i_fetch, i_iwe, i_prom;
    logic [AW-1:0] i_pc;
    logic [DW-1:0] i_iwr, i_iram;
    logic          i_valid, i_busy, i_err;

    // external instance
    logic          e_reset, e_fetch, e_iwe, e_prom;
    logic [AW-1:0] e_pc;
    logic [DW-1:0] e_iwr, e_iram;
    logic          e_valid, e_busy, e_err;

    iram_ctl_if #(.ADDR_W(AW), .DATA_W(DW)) int_bus();
    iram_ctl_if #(.ADDR_W(AW), .DATA_W(DW)) ext_bus();

    iram_ctl #(.ADDR_W(AW), .DATA_W(DW), .EXT_MEM(0), .TMO_W(8)) dut_int (
        .clk(clk), .reset(i_reset), .pc(i_pc), .fetch(i_fetch), .iwe(i_iwe),
        .iwr(i_iwr), .promdisabled(i_prom), .iram(i_iram), .iram_valid(i_valid),
        .busy(i_busy), .err_timeout(i_err), .mcr(int_bus.master)
    );

    iram_ctl #(.ADDR_W(AW), .DATA_W(DW), .EXT_MEM(1), .TMO_W(4)) dut_ext (
        .clk(clk), .reset(e_reset), .pc(e_pc), .fetch(e_fetch), .iwe(e_iwe),
        .iwr(e_iwr), .promdisabled(e_prom), .iram(e_iram), .iram_valid(e_valid),
        .busy(e_busy), .err_timeout(e_err), .mcr(ext_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference state
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] exp_i_iram = '0;
    logic [DW-1:0] exp_e_iram = '0;
    logic          exp_e_err  = 1'b0;
    logic [AW-1:0] pool [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // One internal-store cycle: present a command, step the reference map.
    task automatic int_step(input logic w, input logic f, input logic p,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic fa;
        logic ev;
        i_iwe = w; i_fetch = f; i_prom = p; i_pc = a; i_iwr = d;
        int_bus.mcr_ack     = 1'($urandom_range(0, 1));
        int_bus.mcr_data_in = rnd_word();
        fa = f & p & ~w;
        ev = 1'b0;
        @(posedge clk);
        if (fa) begin
            exp_i_iram = ref_mem[int'(a)];
            ev = 1'b1;
        end
        if (w) ref_mem[int'(a)] = d;
        #1;
        chk("i_iram", 64'(i_iram), 64'(exp_i_iram));
        chk("i_valid", 64'(i_valid), 64'(ev));
        chk("i_busy", 64'(i_busy), 64'd0);
        chk("i_mcr_req", 64'(int_bus.mcr_req), 64'd0);
        i_iwe = 1'b0; i_fetch = 1'b0;
    endtask

    // One external command with an ack after dly cycles (dly > TMAX: none).
    task automatic ext_op(input logic w, input logic f, input logic p,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int dly, input logic [DW-1:0] rdata);
        logic acc;
        logic ev;
        acc = w | (f & p);
        ev  = 1'b0;
        e_iwe = w; e_fetch = f; e_prom = p; e_pc = a; e_iwr = d;
        @(posedge clk); #1;
        e_iwe = 1'b0; e_fetch = 1'b0;
        if (!acc) begin
            chk("e_ign_req", 64'(ext_bus.mcr_req), 64'd0);
            chk("e_ign_busy", 64'(e_busy), 64'd0);
            chk("e_ign_valid", 64'(e_valid), 64'd0);
        end else begin
            chk("e_addr", 64'(ext_bus.mcr_addr), 64'(a));
            chk("e_write", 64'(ext_bus.mcr_write), 64'(w));
            chk("e_dout", 64'(ext_bus.mcr_data_out), 64'(d));
            for (int c = 0; c <= TMAX; c++) begin
                chk("e_req_hi", 64'(ext_bus.mcr_req), 64'd1);
                chk("e_busy_hi", 64'(e_busy), 64'd1);
                chk("e_valid_lo", 64'(e_valid), 64'd0);
                if (c == dly) begin
                    ext_bus.mcr_ack = 1'b1;
                    ext_bus.mcr_data_in = rdata;
                end
                @(posedge clk); #1;
                ext_bus.mcr_ack = 1'b0;
                ext_bus.mcr_data_in = rnd_word();
                if (c == dly) break;
            end
            if (dly <= TMAX) begin
                if (!w) begin
                    exp_e_iram = rdata;
                    ev = 1'b1;
                end
            end else begin
                exp_e_err = 1'b1;
            end
            chk("e_req_lo", 64'(ext_bus.mcr_req), 64'd0);
            chk("e_busy_lo", 64'(e_busy), 64'd0);
            chk("e_valid", 64'(e_valid), 64'(ev));
        end
        chk("e_iram", 64'(e_iram), 64'(exp_e_iram));
        chk("e_err", 64'(e_err), 64'(exp_e_err));
    endtask

    initial begin
        i_reset = 1'b1; i_fetch = 1'b0; i_iwe = 1'b0; i_prom = 1'b1; i_pc = '0; i_iwr = '0;
        e_reset = 1'b1; e_fetch = 1'b0; e_iwe = 1'b0; e_prom = 1'b1; e_pc = '0; e_iwr = '0;
        int_bus.mcr_ack = 1'b0; int_bus.mcr_data_in = '0;
        ext_bus.mcr_ack = 1'b0; ext_bus.mcr_data_in = '0;
        pool[0] = 14'h0000; pool[1] = 14'h0005; pool[2] = 14'h3FFF; pool[3] = 14'h0123;
        pool[4] = 14'h2000; pool[5] = 14'h1555; pool[6] = 14'h0001; pool[7] = 14'h3FFE;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0; e_reset = 1'b0;
        chk("i_rst_iram", 64'(i_iram), 64'd0);
        chk("i_rst_valid", 64'(i_valid), 64'd0);
        chk("i_rst_err", 64'(i_err), 64'd0);
        chk("e_rst_iram", 64'(e_iram), 64'd0);
        chk("e_rst_valid", 64'(e_valid), 64'd0);
        chk("e_rst_busy", 64'(e_busy), 64'd0);
        chk("e_rst_err", 64'(e_err), 64'd0);
        chk("e_rst_req", 64'(ext_bus.mcr_req), 64'd0);
        chk("e_rst_write", 64'(ext_bus.mcr_write), 64'd0);
        chk("e_rst_addr", 64'(ext_bus.mcr_addr), 64'd0);
        chk("e_rst_dout", 64'(ext_bus.mcr_data_out), 64'd0);

        // internal store: directed cases
        int_step(1'b1, 1'b0, 1'b1, 14'h0005, 49'h1_2345_6789_ABCD);
        int_step(1'b0, 1'b1, 1'b1, 14'h0005, 49'h0);
        chk("i_dir_word", 64'(i_iram), 64'h1_2345_6789_ABCD);
        int_step(1'b1, 1'b1, 1'b1, 14'h3FFF, 49'h0_AAAA_5555_0F0F);
        int_step(1'b0, 1'b1, 1'b1, 14'h3FFF, 49'h0);
        chk("i_dir_top", 64'(i_iram), 64'h0_AAAA_5555_0F0F);
        int_step(1'b0, 1'b1, 1'b0, 14'h0005, 49'h0);
        int_step(1'b0, 1'b1, 1'b1, 14'h0005, 49'h0);
        int_step(1'b0, 1'b1, 1'b1, 14'h3FFF, 49'h0);
        int_step(1'b1, 1'b0, 1'b0, 14'h0000, 49'h1_FFFF_FFFF_FFFF);

        // internal store: seed the pool, then random traffic
        for (int k = 0; k < 8; k++) int_step(1'b1, 1'b0, 1'b1, pool[k], rnd_word());
        for (int k = 0; k < 150; k++) begin
            int_step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 4) != 0), pool[$urandom_range(0, 7)], rnd_word());
        end

        // external: directed fetch with a 4-cycle ack delay
        ext_op(1'b0, 1'b1, 1'b1, 14'h0123, 49'h0, 4, 49'h0_0000_0000_BEEF);
        chk("e_dir_beef", 64'(e_iram), 64'h0_0000_0000_BEEF);
        // external: write, then fetch ignored under PROM
        ext_op(1'b1, 1'b1, 1'b0, 14'h0040, 49'h1_0000_0000_0001, 2, 49'h0_1111_1111_1111);
        ext_op(1'b0, 1'b1, 1'b0, 14'h0041, 49'h0, 0, 49'h0);
        // ack on the last allowed cycle, then timeout
        ext_op(1'b0, 1'b1, 1'b1, 14'h0042, 49'h0, TMAX, 49'h0_0000_0000_CAFE);
        ext_op(1'b0, 1'b1, 1'b1, 14'h0043, 49'h0, 99, 49'h0_0000_0000_DEAD);
        // late ack in idle is ignored
        ext_bus.mcr_ack = 1'b1; ext_bus.mcr_data_in = 49'h1_BAD0_BAD0_BAD0;
        @(posedge clk); #1;
        ext_bus.mcr_ack = 1'b0;
        chk("e_late_valid", 64'(e_valid), 64'd0);
        chk("e_late_iram", 64'(e_iram), 64'(exp_e_iram));
        chk("e_late_busy", 64'(e_busy), 64'd0);
        chk("e_late_err", 64'(e_err), 64'(exp_e_err));

        // external: random ops, some timing out
        for (int k = 0; k < 40; k++) begin
            ext_op(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0),
                   1'($urandom_range(0, 5) != 0), 14'($urandom_range(0, 16383)),
                   rnd_word(), int'($urandom_range(0, 17)), rnd_word());
        end

        // external: reset while a request is outstanding
        e_fetch = 1'b1; e_prom = 1'b1; e_pc = 14'h0777;
        @(posedge clk); #1;
        e_fetch = 1'b0;
        chk("e_mid_req", 64'(ext_bus.mcr_req), 64'd1);
        e_reset = 1'b1;
        @(posedge clk); #1;
        e_reset = 1'b0;
        exp_e_iram = '0; exp_e_err = 1'b0;
        chk("e_mid_rst_req", 64'(ext_bus.mcr_req), 64'd0);
        chk("e_mid_rst_busy", 64'(e_busy), 64'd0);
        chk("e_mid_rst_err", 64'(e_err), 64'd0);
        chk("e_mid_rst_iram", 64'(e_iram), 64'd0);
        ext_op(1'b0, 1'b1, 1'b1, 14'h0010, 49'h0, 1, 49'h0_0000_1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
